// File: rtl/ctl_reg_reader_if.sv
// Controller-page BRAM port B plus the settings-stream outputs of ctl_reg_reader.
// master = the reader, slave = the BRAM / settings-distribution side.
interface ctl_reg_reader_if;
  logic        bram_en;
  logic        bram_we;
  logic [7:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic        cfg_valid;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [5:0]  update;

  modport master (
    output bram_en, bram_we, bram_addr, bram_din,
    output cfg_valid, cfg_addr, cfg_data, update,
    input  bram_dout
  );

  modport slave (
    input  bram_en, bram_we, bram_addr, bram_din,
    input  cfg_valid, cfg_addr, cfg_data, update,
    output bram_dout
  );
endinterface

// File: rtl/ctl_reg_reader.sv
// Polls the controller register page, streams newly flagged register groups and writes back state/version.
// Optional CTL_READER_ACK_EN: per-group ack toggle register reported in FPGA_STATE[15:8].
module ctl_reg_reader #(
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned BRAM_LATENCY  = 2,
  parameter logic [7:0]  VERSION_MAJOR = 8'h90,
  parameter logic [7:0]  VERSION_MINOR = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ctl_reg_reader_if.master        bus,
  input  logic [7:0]              fpga_state_in,
  output logic                    force_fan,
  output logic                    busy
);

  typedef enum logic [3:0] {
    INIT, INIT_MAJ, INIT_MIN, IDLE, RD_FLAG, WAIT_FLAG, WR_STATE, SCAN, DRAIN, STROBE
  } state_t;

  state_t      state;
  logic [15:0] poll_cnt;
  logic [1:0]  wait_cnt;
  logic [5:0]  prev_flag;
  logic [5:0]  pending;
  logic [2:0]  grp;
  logic [2:0]  next_grp;
  logic [7:0]  end_addr;
  logic        v1, v2;
  logic [7:0]  a1, a2;
  logic [7:0]  ack_byte;

`ifdef CTL_READER_ACK_EN
  logic [7:0] ack_q;
  assign ack_byte = ack_q;
`else
  assign ack_byte = 8'h00;
`endif

  function automatic logic [2:0] lowest_bit(input logic [5:0] p);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (p[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] grp_lo(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h20;
      3'd1:    return 8'h50;
      3'd2:    return 8'h40;
      3'd3:    return 8'hE0;
      3'd4:    return 8'hF0;
      3'd5:    return 8'h10;
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] grp_hi(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h30;
      3'd1:    return 8'h68;
      3'd2:    return 8'h44;
      3'd3:    return 8'hE1;
      3'd4:    return 8'hF7;
      3'd5:    return 8'h13;
      default: return 8'h30;
    endcase
  endfunction

  assign next_grp = lowest_bit(pending);

  // Each state's bus cycle is set up on the edge that enters it, so every port output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      poll_cnt      <= '0;
      wait_cnt      <= '0;
      prev_flag     <= '0;
      pending       <= '0;
      grp           <= '0;
      end_addr      <= '0;
      force_fan     <= 1'b0;
      busy          <= 1'b0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      bus.update    <= '0;
`ifdef CTL_READER_ACK_EN
      ack_q         <= '0;
`endif
    end else begin
      bus.update <= '0;
      case (state)
        INIT: begin
          bus.bram_en   <= 1'b1;
          bus.bram_we   <= 1'b1;
          bus.bram_addr <= 8'h02;
          bus.bram_din  <= {8'h00, VERSION_MAJOR};
          busy          <= 1'b1;
          state         <= INIT_MAJ;
        end
        INIT_MAJ: begin
          bus.bram_addr <= 8'h03;
          bus.bram_din  <= {8'h00, VERSION_MINOR};
          state         <= INIT_MIN;
        end
        INIT_MIN: begin
          bus.bram_en   <= 1'b0;
          bus.bram_we   <= 1'b0;
          bus.bram_addr <= '0;
          bus.bram_din  <= '0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        IDLE: begin
          if (poll_cnt == 16'(POLL_INTERVAL - 1)) begin
            poll_cnt      <= '0;
            bus.bram_en   <= 1'b1;
            bus.bram_addr <= 8'h00;
            busy          <= 1'b1;
            state         <= RD_FLAG;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
          end
        end
        RD_FLAG: begin
          bus.bram_en <= 1'b0;
          wait_cnt    <= '0;
          state       <= WAIT_FLAG;
        end
        WAIT_FLAG: begin
          if (wait_cnt == 2'(BRAM_LATENCY - 1)) begin
            pending       <= bus.bram_dout[5:0] & ~prev_flag;
            prev_flag     <= bus.bram_dout[5:0];
            force_fan     <= bus.bram_dout[13];
            bus.bram_en   <= 1'b1;
            bus.bram_we   <= 1'b1;
            bus.bram_addr <= 8'h01;
            bus.bram_din  <= {ack_byte, fpga_state_in};
            state         <= WR_STATE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        WR_STATE: begin
          bus.bram_we  <= 1'b0;
          bus.bram_din <= '0;
          if (pending != '0) begin
            grp           <= next_grp;
            bus.bram_addr <= grp_lo(next_grp);
            end_addr      <= grp_hi(next_grp);
            state         <= SCAN;
          end else begin
            bus.bram_en   <= 1'b0;
            bus.bram_addr <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        SCAN: begin
          if (bus.bram_addr == end_addr) begin
            bus.bram_en <= 1'b0;
            wait_cnt    <= '0;
            state       <= DRAIN;
          end else begin
            bus.bram_addr <= bus.bram_addr + 8'd1;
          end
        end
        DRAIN: begin
          // Hold the strobe until the last word of the group has left the read pipeline.
          if (wait_cnt == 2'(BRAM_LATENCY - 1)) begin
            bus.update[grp] <= 1'b1;
            pending[grp]    <= 1'b0;
`ifdef CTL_READER_ACK_EN
            ack_q[grp]      <= ~ack_q[grp];
`endif
            state           <= STROBE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        STROBE: begin
          if (pending != '0) begin
            grp           <= next_grp;
            bus.bram_en   <= 1'b1;
            bus.bram_addr <= grp_lo(next_grp);
            end_addr      <= grp_hi(next_grp);
            state         <= SCAN;
          end else begin
            bus.bram_addr <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Scan reads ride a delay line so their address lines up with the BRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else begin
      v1 <= (state == SCAN);
      a1 <= bus.bram_addr;
      v2 <= v1;
      a2 <= a1;
    end
  end

  assign bus.cfg_valid = (BRAM_LATENCY == 1) ? v1 : v2;
  assign bus.cfg_addr  = (BRAM_LATENCY == 1) ? a1 : a2;
  assign bus.cfg_data  = bus.cfg_valid ? bus.bram_dout : 16'h0000;

endmodule
